// File: rtl/scene_compositor.sv
// rtl/scene_compositor.sv - per-pixel sky/floor/sprite compositor with scrolled texture lookup
module scene_compositor #(
  parameter int              WIDTH       = 96,
  parameter int              HEIGHT      = 64,
  parameter int              FLOOR_Y     = 48,
  parameter int              SPR_W       = 8,
  parameter int              SPR_H       = 8,
  parameter logic [15:0]     SKY_COLOR   = 16'h867D,
  parameter logic [15:0]     TRANSPARENT = 16'hF81F,
  parameter int              SCROLL_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  output logic [6:0]  tex_x,
  output logic [6:0]  tex_y,
  input  logic [15:0] tex_data,
  input  logic        spr_valid,
  output logic        spr_ready,
  input  logic [6:0]  spr_x,
  input  logic [5:0]  spr_y,
  input  logic [15:0] spr_color,
  output logic [15:0] oled_data
);

  localparam int NPIX = WIDTH * HEIGHT;

  logic [6:0]  x_c, y_c, tx_c;
  logic        oor_c;
  logic [7:0]  sum_c;
  logic [6:0]  x1, y1, y2;
  logic        oor1, oor2;
  logic        draw2, hit_c;
  logic [15:0] col2;
  logic [7:0]  sx_end, sy_end;
  logic [6:0]  scroll_x;
  logic [3:0]  frame_cnt;
  logic        pending;
  logic [6:0]  sh_x, act_x;
  logic [5:0]  sh_y, act_y;
  logic [15:0] sh_color, act_color;
  logic        act_en;

  // S1 address decode; the 8-bit sum keeps 95+95 from overflowing before the wrap
  always_comb begin
    oor_c = ({19'd0, pixel_index} >= NPIX);
    x_c   = oor_c ? 7'd0 : 7'({19'd0, pixel_index} % WIDTH);
    y_c   = oor_c ? 7'd0 : 7'({19'd0, pixel_index} / WIDTH);
    sum_c = {1'b0, x_c} + {1'b0, scroll_x};
    tx_c  = (sum_c >= 8'(WIDTH)) ? 7'(sum_c - 8'(WIDTH)) : sum_c[6:0];
  end

  // Sprite hit uses unscrolled coordinates so it stays screen-fixed; edges clip
  always_comb begin
    sx_end = {1'b0, act_x} + 8'(SPR_W);
    sy_end = {2'b0, act_y} + 8'(SPR_H);
    hit_c  = act_en && (x1 >= act_x) && ({1'b0, x1} < sx_end) &&
             (y1 >= {1'b0, act_y}) && ({1'b0, y1} < sy_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1 <= '0; y1 <= '0; oor1 <= 1'b0;
      tex_x <= '0; tex_y <= '0;
      y2 <= '0; oor2 <= 1'b0; draw2 <= 1'b0; col2 <= '0;
      oled_data <= '0;
    end else begin
      x1    <= x_c;
      y1    <= y_c;
      oor1  <= oor_c;
      tex_x <= tx_c;
      tex_y <= y_c;
      y2    <= y1;
      oor2  <= oor1;
      draw2 <= hit_c && (act_color != TRANSPARENT);
      col2  <= act_color;
      if (oor2)
        oled_data <= 16'h0000;
      else if (draw2)
        oled_data <= col2;
      else if ({25'd0, y2} >= FLOOR_Y)
        oled_data <= tex_data;
      else
        oled_data <= SKY_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      scroll_x  <= '0;
    end else if (frame_begin) begin
      if (frame_cnt == 4'(SCROLL_DIV - 1)) begin
        frame_cnt <= '0;
        scroll_x  <= (scroll_x == 7'(WIDTH - 1)) ? 7'd0 : scroll_x + 7'd1;
      end else begin
        frame_cnt <= frame_cnt + 4'd1;
      end
    end
  end

  assign spr_ready = !pending;

  // Updates land in the shadow set and only reach the active sprite on a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      sh_x <= '0; sh_y <= '0; sh_color <= '0;
      act_en <= 1'b0; act_x <= '0; act_y <= '0; act_color <= '0;
    end else begin
      if (frame_begin && pending) begin
        act_en    <= 1'b1;
        act_x     <= sh_x;
        act_y     <= sh_y;
        act_color <= sh_color;
        pending   <= 1'b0;
      end else if (spr_valid && !pending) begin
        sh_x     <= spr_x;
        sh_y     <= spr_y;
        sh_color <= spr_color;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scene_compositor.sv
// tb/tb_scene_compositor.sv - scoreboard bench for scene_compositor
module tb_scene_compositor;

  localparam logic [15:0] SKY = 16'h867D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_begin;
  logic [12:0] pixel_index;
  logic [6:0]  tex_x, tex_y;
  logic [15:0] tex_data = 16'h0000;
  logic        spr_valid, spr_ready;
  logic [6:0]  spr_x;
  logic [5:0]  spr_y;
  logic [15:0] spr_color;
  logic [15:0] oled_data;

  scene_compositor dut (
    .clk(clk), .rst_n(rst_n), .frame_begin(frame_begin), .pixel_index(pixel_index),
    .tex_x(tex_x), .tex_y(tex_y), .tex_data(tex_data),
    .spr_valid(spr_valid), .spr_ready(spr_ready), .spr_x(spr_x), .spr_y(spr_y),
    .spr_color(spr_color), .oled_data(oled_data)
  );

  always #5 clk = ~clk;

  // Texture stage stand-in: registered, colour encodes the requested coordinate
  always @(posedge clk) tex_data <= {2'b10, tex_y, tex_x};

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
    string       name;
  } ent_t;

  ent_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   frames = 0;

  always @(posedge clk) cyc++;

  function automatic logic [15:0] tex_fn(int x, int y);
    logic [6:0] xx, yy;
    xx = 7'(x);
    yy = 7'(y);
    return {2'b10, yy, xx};
  endfunction

  function automatic int scr();
    return (frames / 4) % 96;
  endfunction

  task automatic expect_at(int d, int k, logic [15:0] e, string n);
    ent_t t;
    t.due = d; t.kind = k; t.exp = e; t.name = n;
    sb.push_back(t);
  endtask

  // Monitor: compares every entry due this cycle, flags any that slipped past
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        logic [15:0] act;
        case (sb[i].kind)
          0:       act = oled_data;
          1:       act = {9'd0, tex_x};
          2:       act = {9'd0, tex_y};
          default: act = {15'd0, spr_ready};
        endcase
        total++;
        if (sb[i].due < cyc) begin
          bad++;
          $display("FAIL %s: check overdue (due %0d, now %0d)", sb[i].name, sb[i].due, cyc);
        end else if (act !== sb[i].exp) begin
          bad++;
          $display("FAIL %s: got %h expected %h", sb[i].name, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pix(int idx, logic [15:0] eo, int etx, int ety, string n);
    pixel_index = 13'(idx);
    if (etx >= 0) expect_at(cyc + 1, 1, 16'(etx), {n, "_tx"});
    if (ety >= 0) expect_at(cyc + 1, 2, 16'(ety), {n, "_ty"});
    expect_at(cyc + 3, 0, eo, n);
    tick();
  endtask

  task automatic pulse(int n);
    for (int i = 0; i < n; i++) begin
      frame_begin = 1'b1;
      tick();
      frame_begin = 1'b0;
      frames++;
    end
    idle(1);
  endtask

  task automatic spr(int x, int y, logic [15:0] c);
    spr_valid = 1'b1;
    spr_x = 7'(x); spr_y = 6'(y); spr_color = c;
    tick();
    spr_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_begin = 1'b0; pixel_index = '0;
    spr_valid = 1'b0; spr_x = '0; spr_y = '0; spr_color = '0;
    idle(3);
    expect_at(cyc, 0, 16'h0000, "rst_oled");
    expect_at(cyc, 1, 16'h0000, "rst_texx");
    expect_at(cyc, 3, 16'h0001, "rst_ready");
    tick();
    rst_n = 1'b1;

    pix(0,    SKY,              0,  0,  "sky0");
    pix(4800, tex_fn(0, 50),    0,  50, "floor");
    pix(6144, 16'h0000,         0,  0,  "oor");
    pix(8191, 16'h0000,         0,  0,  "oor_max");
    pix(6143, tex_fn(95, 63),   95, 63, "last_px");
    pix(4703, tex_fn(95, 48),   95, 48, "floor_edge");
    pix(4607, SKY,              95, 47, "sky_edge");
    idle(4);

    pulse(16);
    pix(95,   SKY,              3,  0,  "scroll3");
    pix(4800, tex_fn(4, 50),    4,  50, "scroll_floor");
    idle(4);
    pulse(364);
    pix(0,    SKY,              95, 0,  "scroll95");
    idle(4);
    pulse(4);
    pix(0,    SKY,              0,  0,  "scroll_wrap");
    idle(4);

    spr(10, 20, 16'h07E0);
    expect_at(cyc, 3, 16'h0000, "ready_low");
    pix(1932, SKY, -1, -1, "pre_commit");
    idle(3);
    pulse(1);
    expect_at(cyc, 3, 16'h0001, "ready_high");
    pix(1932, 16'h07E0, -1, -1, "spr_hit");
    pix(1938, SKY,      -1, -1, "x18_miss");
    pix(1937, 16'h07E0, -1, -1, "x17_hit");
    pix(1929, SKY,      -1, -1, "x9_miss");
    pix(2602, 16'h07E0, -1, -1, "y27_hit");
    pix(2698, SKY,      -1, -1, "y28_miss");
    idle(4);

    spr(60, 5, 16'hF800);
    spr_valid = 1'b1; spr_x = 7'd50; spr_y = 6'd30; spr_color = 16'h001F;
    for (int i = 0; i < 3; i++) begin
      expect_at(cyc, 3, 16'h0000, "held_ready");
      tick();
    end
    spr_valid = 1'b0;
    pulse(1);
    pix(540,  16'hF800, -1, -1, "first_kept");
    pix(2930, SKY,      -1, -1, "second_lost");
    idle(4);

    spr(0, 50, 16'h001F);
    pulse(1);
    pix(4803, 16'h001F, -1, -1, "spr_floor");
    idle(4);
    spr(0, 50, 16'hF81F);
    pulse(1);
    pix(4803, tex_fn((3 + scr()) % 96, 50), -1, -1, "transparent");
    idle(4);
    spr(92, 60, 16'h07E0);
    pulse(1);
    pix(6143, 16'h07E0, -1, -1, "corner_clip");
    pix(5760, tex_fn(scr() % 96, 60), -1, -1, "no_wrap");
    idle(4);

    spr_valid = 1'b1; frame_begin = 1'b1;
    spr_x = 7'd40; spr_y = 6'd10; spr_color = 16'hF800;
    tick();
    spr_valid = 1'b0; frame_begin = 1'b0;
    frames++;
    pix(1000, SKY, -1, -1, "same_cyc_hidden");
    idle(4);
    pulse(1);
    pix(1000, 16'hF800, -1, -1, "same_cyc_shown");
    idle(4);

    pixel_index = 13'd1000;
    idle(2);
    rst_n = 1'b0;
    expect_at(cyc, 0, 16'h0000, "midrst_oled");
    expect_at(cyc, 1, 16'h0000, "midrst_texx");
    expect_at(cyc, 3, 16'h0001, "midrst_ready");
    tick();
    rst_n = 1'b1;
    frames = 0;
    pix(1000, SKY, 40, 10, "after_rst");
    idle(5);

    if (sb.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d checks left unevaluated, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
